// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic feeder slice.
//   feed_state_t : feeder FSM states (IDLE, RUN, DRAIN)
//   drain_beats  : number of zero beats needed to flush an n x p array
package systolic_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } feed_state_t;

   function automatic int drain_beats(input int n, input int p);
      return n + p - 1;
   endfunction

endpackage

// File: rtl/systolic_skew_feeder_if.sv
// Bundle between upstream row source, the skew feeder and systolic_array.
//   in_valid/in_last/in_data : row stream into the feeder
//   in_ready                 : feeder accepts the row this cycle
//   ds_ready                 : array ready (weights loaded), level signal
//   out_valid/out_start/out_data : skewed beat stream towards the array
// master = row source / array side, slave = feeder.
interface systolic_skew_feeder_if #(
   parameter int BitSize     = 8,
   parameter int NumOfInputs = 2
);
   logic                           in_valid;
   logic                           in_last;
   logic [NumOfInputs*BitSize-1:0] in_data;
   logic                           in_ready;
   logic                           ds_ready;
   logic                           out_valid;
   logic                           out_start;
   logic [NumOfInputs*BitSize-1:0] out_data;

   modport master (
      output in_valid, in_last, in_data, ds_ready,
      input  in_ready, out_valid, out_start, out_data
   );

   modport slave (
      input  in_valid, in_last, in_data, ds_ready,
      output in_ready, out_valid, out_start, out_data
   );
endinterface

// File: rtl/skew_delay_line.sv
// Enable-shifted register chain used for one diagonal lane of the feeder.
//   clk, res_n : clock, synchronous active-low reset (clears every stage)
//   en         : shift one stage when high, hold otherwise
//   din        : value loaded into stage 0
//   dout       : last stage (Depth cycles of enable after din)
module skew_delay_line #(
   parameter int BitSize = 8,
   parameter int Depth   = 1
) (
   input  logic               clk,
   input  logic               res_n,
   input  logic               en,
   input  logic [BitSize-1:0] din,
   output logic [BitSize-1:0] dout
);

   logic [BitSize-1:0] stage_reg [Depth];

   always_ff @(posedge clk) begin
      if (!res_n) begin
         for (int i = 0; i < Depth; i++) begin
            stage_reg[i] <= '0;
         end
      end else if (en) begin
         stage_reg[0] <= din;
         for (int i = 1; i < Depth; i++) begin
            stage_reg[i] <= stage_reg[i-1];
         end
      end
   end

   assign dout = stage_reg[Depth-1];

endmodule

// File: rtl/systolic_skew_feeder.sv
// Upstream feeder for systolic_array: takes one row-major row per accepted
// beat and emits the skewed diagonal stream (element e delayed e beats),
// followed by drain zero beats that flush the array.
//   clk, res_n : clock, synchronous active-low reset
//   bus        : slave side of systolic_skew_feeder_if (row in, beats out)
module systolic_skew_feeder
   import systolic_pkg::*;
#(
   parameter int BitSize     = 8,
   parameter int NumOfInputs = 2,
   parameter int NumOfNerves = 2
) (
   input  logic                   clk,
   input  logic                   res_n,
   systolic_skew_feeder_if.slave  bus
);

   localparam int DrainBeats = drain_beats(NumOfInputs, NumOfNerves);
   localparam int CntW       = $clog2(DrainBeats + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(DrainBeats - 1);

   feed_state_t     state_reg, state_next;
   logic [CntW-1:0] cnt_reg, cnt_next;
   logic            out_valid_reg, out_start_reg;

   logic in_ready;
   logic accept;
   logic drain_beat;
   logic beat;

   // in_ready is forced low while reset is held so nothing is accepted then.
   assign in_ready   = res_n && bus.ds_ready && (state_reg != DRAIN);
   assign accept     = bus.in_valid && in_ready;
   assign drain_beat = res_n && (state_reg == DRAIN) && bus.ds_ready;
   assign beat       = accept || drain_beat;

   always_ff @(posedge clk) begin
      if (!res_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         out_valid_reg <= 1'b0;
         out_start_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         out_valid_reg <= beat;
         out_start_reg <= accept && (state_reg == IDLE);
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      unique case (state_reg)
         IDLE, RUN: begin
            if (accept) begin
               if (bus.in_last) begin
                  state_next = DRAIN;
                  cnt_next   = '0;
               end else begin
                  state_next = RUN;
               end
            end
         end
         DRAIN: begin
            if (bus.ds_ready) begin
               if (cnt_reg == CntLast) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // Lane gi needs gi+1 stages: one for the registered output, gi for skew.
   // During DRAIN stage 0 is fed zeros so trailing diagonal slots stay clean.
   logic [NumOfInputs*BitSize-1:0] out_data;

   genvar gi;
   generate
      for (gi = 0; gi < NumOfInputs; gi++) begin : g_lane
         localparam int Hi = (NumOfInputs - gi) * BitSize - 1;
         logic [BitSize-1:0] lane_din;

         assign lane_din = (state_reg == DRAIN) ? '0 : bus.in_data[Hi -: BitSize];

         skew_delay_line #(
            .BitSize (BitSize),
            .Depth   (gi + 1)
         ) u_line (
            .clk   (clk),
            .res_n (res_n),
            .en    (beat),
            .din   (lane_din),
            .dout  (out_data[Hi -: BitSize])
         );
      end
   endgenerate

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_reg;
   assign bus.out_start = out_start_reg;
   assign bus.out_data  = out_data;

endmodule

// File: tb/tb_systolic_skew_feeder.sv
module tb_systolic_skew_feeder;

   localparam int W = 8;
   localparam int N = 3;
   localparam int P = 2;
   localparam int D = N + P - 1;
   localparam int MAXM = 16;

   logic clk = 1'b0;
   logic res_n;

   always #5 clk = ~clk;

   systolic_skew_feeder_if #(.BitSize(W), .NumOfInputs(N)) bus_if ();

   systolic_skew_feeder #(
      .BitSize     (W),
      .NumOfInputs (N),
      .NumOfNerves (P)
   ) dut (
      .clk   (clk),
      .res_n (res_n),
      .bus   (bus_if.slave)
   );

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Monitor: collect every presented beat; between beats the data must hold.
   logic [N*W:0]   act_q [$];
   logic [N*W-1:0] prev_data = '0;
   bit             mon_en = 1'b0;

   always @(negedge clk) begin
      if (bus_if.out_valid === 1'b1) begin
         act_q.push_back({bus_if.out_start, bus_if.out_data});
      end else if (mon_en) begin
         chk("held_data", bus_if.out_data, prev_data);
         chk("start_no_vld", bus_if.out_start, 1'b0);
      end
      prev_data = bus_if.out_data;
   end

   logic [W-1:0] rows [MAXM][N];

   function automatic logic [N*W-1:0] pack_row(input int r);
      logic [N*W-1:0] v;
      v = '0;
      for (int e = 0; e < N; e++) v[(N-e)*W-1 -: W] = rows[r][e];
      return v;
   endfunction

   // Reference: beat k carries element e of row k-e, zero where no such row.
   task automatic compare_batch(input int m);
      logic [N*W:0] b;
      logic [W-1:0] ev;
      chk("beat_count", act_q.size(), m + D);
      for (int k = 0; k < m + D && k < act_q.size(); k++) begin
         b = act_q[k];
         chk("beat_start", b[N*W], (k == 0) ? 1 : 0);
         for (int e = 0; e < N; e++) begin
            ev = ((k - e) >= 0 && (k - e) < m) ? rows[k-e][e] : '0;
            chk($sformatf("b%0d_lane%0d", k, e), b[(N-e)*W-1 -: W], ev);
         end
      end
      $display("batch m=%0d beats=%0d checks=%0d failures=%0d", m, act_q.size(), checks, failures);
   endtask

   task automatic run_batch(input int m, input int bub_pct, input int dsl_pct);
      int  idx = 0;
      int  dr = 0;
      int  guard = 0;
      bit  first_acc = 1'b0;
      act_q.delete();
      for (int r = 0; r < m; r++)
         for (int e = 0; e < N; e++) rows[r][e] = W'($urandom_range(1, 255));
      while (idx < m) begin
         @(negedge clk);
         if (first_acc) begin
            chk("start_after_acc", bus_if.out_start, 1'b1);
            chk("vld_after_acc", bus_if.out_valid, 1'b1);
            first_acc = 1'b0;
         end
         bus_if.ds_ready = ($urandom_range(99) >= dsl_pct);
         bus_if.in_valid = ($urandom_range(99) >= bub_pct);
         bus_if.in_data  = pack_row(idx);
         bus_if.in_last  = bus_if.in_valid ? (idx == m - 1) : 1'($urandom_range(1));
         #1;
         chk("rdy_run", bus_if.in_ready, bus_if.ds_ready);
         if (bus_if.in_valid && bus_if.in_ready) begin
            if (idx == 0) first_acc = 1'b1;
            idx++;
         end
         guard++;
         if (guard > 2000) begin
            chk("accept_timeout", idx, m);
            idx = m;
         end
      end
      while (dr < D) begin
         @(negedge clk);
         if (first_acc) begin
            chk("start_after_acc", bus_if.out_start, 1'b1);
            chk("vld_after_acc", bus_if.out_valid, 1'b1);
            first_acc = 1'b0;
         end
         bus_if.ds_ready = ($urandom_range(99) >= dsl_pct);
         bus_if.in_valid = 1'($urandom_range(1));
         bus_if.in_data  = N*W'($urandom);
         bus_if.in_last  = 1'($urandom_range(1));
         #1;
         chk("rdy_drain", bus_if.in_ready, 1'b0);
         if (bus_if.ds_ready) dr++;
      end
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      bus_if.ds_ready = 1'($urandom_range(1));
      #1;
      chk("rdy_idle", bus_if.in_ready, bus_if.ds_ready);
      compare_batch(m);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      res_n           = 1'b0;
      bus_if.in_valid = 1'b1;
      bus_if.in_last  = 1'b0;
      bus_if.in_data  = '1;
      bus_if.ds_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         #1;
         chk("rst_vld", bus_if.out_valid, 1'b0);
         chk("rst_start", bus_if.out_start, 1'b0);
         chk("rst_data", bus_if.out_data, '0);
         chk("rst_rdy", bus_if.in_ready, 1'b0);
      end
      @(negedge clk);
      res_n           = 1'b1;
      bus_if.in_valid = 1'b0;
      @(negedge clk);
      mon_en = 1'b1;

      run_batch(2, 0, 0);
      run_batch(3, 40, 0);
      run_batch(3, 0, 40);
      run_batch(1, 0, 0);
      run_batch(2, 0, 0);

      // Reset in the middle of a drain, then a fresh batch must be clean.
      act_q.delete();
      for (int e = 0; e < N; e++) rows[0][e] = W'(8'h11 * (e + 1));
      @(negedge clk);
      bus_if.ds_ready = 1'b1;
      bus_if.in_valid = 1'b1;
      bus_if.in_last  = 1'b1;
      bus_if.in_data  = pack_row(0);
      @(negedge clk);
      bus_if.in_valid = 1'b0;
      bus_if.in_last  = 1'b0;
      @(negedge clk);
      @(negedge clk);
      mon_en = 1'b0;
      res_n  = 1'b0;
      @(negedge clk);
      #1;
      chk("mid_rst_vld", bus_if.out_valid, 1'b0);
      chk("mid_rst_start", bus_if.out_start, 1'b0);
      chk("mid_rst_data", bus_if.out_data, '0);
      chk("mid_rst_rdy", bus_if.in_ready, 1'b0);
      res_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_rdy", bus_if.in_ready, 1'b1);
      chk("post_rst_vld", bus_if.out_valid, 1'b0);
      act_q.delete();
      mon_en = 1'b1;

      run_batch(3, 0, 0);
      for (int t = 0; t < 10; t++) begin
         run_batch($urandom_range(1, 6), $urandom_range(0, 40), $urandom_range(0, 40));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
